rob_commit: RTL and testbench



---
 rtl/rob_commit_pkg.sv | 64 ++++++
 rtl/rob_commit_ptr.sv | 25 ++
 rtl/rob_commit.sv | 173 +++++++++++++++++
 tb/tb_rob_commit.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_commit_pkg.sv
// Shared definitions for the ROB commit controller: entry state codes,
// head write-enable masks, FSM states and instruction decode helpers.
package rob_commit_pkg;

  localparam int unsigned MODE_WIDTH      = 2;
  localparam int unsigned ROB_STATE_WIDTH = 3;
  localparam int unsigned ROB_WRITE_WIDTH = 6;
  localparam int unsigned INSTR_WIDTH     = 32;
  localparam int unsigned RW_WIDTH        = 5;

  // ROB entry lifecycle states
  typedef enum logic [ROB_STATE_WIDTH-1:0] {
    ROB_STATE_UNUSED          = 3'd0,
    ROB_STATE_BUSY            = 3'd1,
    ROB_STATE_COMPLETE        = 3'd2,
    ROB_STATE_WAITING_CACHE   = 3'd3,
    ROB_STATE_ACCESSING_CACHE = 3'd4,
    ROB_STATE_EXCEPTION       = 3'd5
  } rob_state_e;

  // Field write-enable bit positions within the ROB head write mask
  localparam int unsigned ROB_WRITE_ENABLE_STATE_BIT = 5;
  localparam int unsigned ROB_WRITE_ENABLE_VALUE_BIT = 4;
  localparam int unsigned ROB_WRITE_ENABLE_ADDR_BIT  = 3;
  localparam int unsigned ROB_WRITE_ENABLE_PC_BIT    = 2;
  localparam int unsigned ROB_WRITE_ENABLE_INSTR_BIT = 1;
  localparam int unsigned ROB_WRITE_ENABLE_MODE_BIT  = 0;

  localparam logic [ROB_WRITE_WIDTH-1:0] ROB_WRITE_ENABLE_STATE = 6'b100000;
  localparam logic [ROB_WRITE_WIDTH-1:0] ROB_WRITE_ENABLE_NONE  = 6'b000000;

  // Commit controller FSM
  typedef enum logic [1:0] {
    FSM_RUN        = 2'd0,
    FSM_STORE_WAIT = 2'd1,
    FSM_FLUSH      = 2'd2
  } commit_state_e;

  // RV32 opcodes that produce a destination register
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // True when the instruction writes a register other than x0
  function automatic logic has_rw(input logic [INSTR_WIDTH-1:0] instr);
    logic w_op;
    case (instr[6:0])
      OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_LUI,
      OPC_AUIPC, OPC_JAL, OPC_JALR: w_op = 1'b1;
      default:                      w_op = 1'b0;
    endcase
    return w_op && (instr[11:7] != 5'd0);
  endfunction

  // Destination register index
  function automatic logic [RW_WIDTH-1:0] get_rw(input logic [INSTR_WIDTH-1:0] instr);
    return instr[11:7];
  endfunction

endpackage

// File: rtl/rob_commit_ptr.sv
// Wrapping ROB pointer: clears to zero, otherwise advances by one mod 2**W.
module rob_commit_ptr #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_clear,
  input  logic         i_inc,
  output logic [W-1:0] o_ptr
);

  logic [W-1:0] r_ptr;

  // Pointer register; natural overflow provides the wrap
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_ptr <= '0;
    end else if (i_inc) begin
      r_ptr <= r_ptr + W'(1);
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/rob_commit.sv
// ROB commit controller: owns head/tail, grants allocation, retires the head
// entry in order (register writeback, store handshake, exception flush).
module rob_commit
  import rob_commit_pkg::*;
#(
  parameter int unsigned ROB_WIDTH   = 3,
  parameter int unsigned DATA_SIZE   = 32,
  parameter int unsigned VADDR_WIDTH = 32,
  parameter int unsigned REG_WIDTH   = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_alloc_valid,
  output logic                       o_alloc_ready,
  output logic [ROB_WIDTH-1:0]       o_alloc_tag,
  output logic [ROB_WIDTH-1:0]       o_head,
  output logic [ROB_WIDTH-1:0]       o_tail,
  input  logic [ROB_WIDTH:0]         i_empty_entries,
  input  logic [ROB_STATE_WIDTH-1:0] i_state_head,
  input  logic [VADDR_WIDTH-1:0]     i_addr_head,
  input  logic [VADDR_WIDTH-1:0]     i_pc_head,
  input  logic [DATA_SIZE-1:0]       i_value_head,
  input  logic [INSTR_WIDTH-1:0]     i_instr_head,
  input  logic [MODE_WIDTH-1:0]      i_mode_head,
  output logic [ROB_WRITE_WIDTH-1:0] o_write_head,
  output logic [ROB_STATE_WIDTH-1:0] o_state_head_write,
  output logic                       o_rf_we,
  output logic [REG_WIDTH-1:0]       o_rf_waddr,
  output logic [DATA_SIZE-1:0]       o_rf_wdata,
  output logic                       o_st_req,
  output logic [VADDR_WIDTH-1:0]     o_st_addr,
  output logic [DATA_SIZE-1:0]       o_st_data,
  input  logic                       i_st_grant,
  input  logic                       i_st_done,
  output logic                       o_exc_valid,
  output logic [VADDR_WIDTH-1:0]     o_exc_pc,
  output logic [VADDR_WIDTH-1:0]     o_exc_addr,
  output logic [MODE_WIDTH-1:0]      o_exc_mode,
  output logic                       o_rob_clean,
  output logic [31:0]                o_commit_count
);

  commit_state_e r_state;
  commit_state_e w_state_next;
  rob_state_e    w_head_state;
  logic          w_retire;
  logic          w_clear;
  logic          w_alloc;
  logic [31:0]   r_commit_count;

  assign w_head_state = rob_state_e'(i_state_head);

  // Next-state and combinational commit outputs
  always_comb begin
    w_state_next       = r_state;
    w_retire           = 1'b0;
    w_clear            = 1'b0;
    o_write_head       = ROB_WRITE_ENABLE_NONE;
    o_state_head_write = ROB_STATE_WIDTH'(ROB_STATE_UNUSED);
    o_rf_we            = 1'b0;
    o_rf_waddr         = '0;
    o_rf_wdata         = '0;
    o_st_req           = 1'b0;
    o_st_addr          = '0;
    o_st_data          = '0;
    o_exc_valid        = 1'b0;
    o_exc_pc           = '0;
    o_exc_addr         = '0;
    o_exc_mode         = '0;
    o_rob_clean        = 1'b0;
    case (r_state)
      FSM_RUN: begin
        case (w_head_state)
          ROB_STATE_COMPLETE: begin
            w_retire           = 1'b1;
            o_write_head       = ROB_WRITE_ENABLE_STATE;
            o_state_head_write = ROB_STATE_WIDTH'(ROB_STATE_UNUSED);
            if (has_rw(i_instr_head)) begin
              o_rf_we    = 1'b1;
              o_rf_waddr = REG_WIDTH'(get_rw(i_instr_head));
              o_rf_wdata = i_value_head;
            end
          end
          ROB_STATE_WAITING_CACHE: begin
            o_st_req  = 1'b1;
            o_st_addr = i_addr_head;
            o_st_data = i_value_head;
            if (i_st_grant) begin
              o_write_head       = ROB_WRITE_ENABLE_STATE;
              o_state_head_write = ROB_STATE_WIDTH'(ROB_STATE_ACCESSING_CACHE);
              w_state_next       = FSM_STORE_WAIT;
            end
          end
          // A store already in the cache (e.g. after reset) waits like STORE_WAIT
          ROB_STATE_ACCESSING_CACHE: begin
            if (i_st_done) begin
              w_retire           = 1'b1;
              o_write_head       = ROB_WRITE_ENABLE_STATE;
              o_state_head_write = ROB_STATE_WIDTH'(ROB_STATE_UNUSED);
            end
          end
          ROB_STATE_EXCEPTION: begin
            o_exc_valid  = 1'b1;
            o_exc_pc     = i_pc_head;
            o_exc_addr   = i_addr_head;
            o_exc_mode   = i_mode_head;
            o_rob_clean  = 1'b1;
            w_clear      = 1'b1;
            w_state_next = FSM_FLUSH;
          end
          default: ;
        endcase
      end
      FSM_STORE_WAIT: begin
        if (i_st_done) begin
          w_retire           = 1'b1;
          o_write_head       = ROB_WRITE_ENABLE_STATE;
          o_state_head_write = ROB_STATE_WIDTH'(ROB_STATE_UNUSED);
          w_state_next       = FSM_RUN;
        end
      end
      FSM_FLUSH: begin
        w_state_next = FSM_RUN;
      end
      default: begin
        w_state_next = FSM_RUN;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= FSM_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  assign o_alloc_ready = (r_state != FSM_FLUSH) && !o_rob_clean &&
                         (i_empty_entries != '0);
  assign w_alloc       = i_alloc_valid && o_alloc_ready;

  rob_commit_ptr #(.W(ROB_WIDTH)) u_head_ptr (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_clear),
    .i_inc   (w_retire),
    .o_ptr   (o_head)
  );

  rob_commit_ptr #(.W(ROB_WIDTH)) u_tail_ptr (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_clear),
    .i_inc   (w_alloc),
    .o_ptr   (o_tail)
  );

  assign o_alloc_tag = o_tail;

  // Retired-instruction counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_commit_count <= '0;
    end else if (w_retire) begin
      r_commit_count <= r_commit_count + 32'd1;
    end
  end

  assign o_commit_count = r_commit_count;

endmodule

// File: tb/tb_rob_commit.sv
// Scoreboard bench for rob_commit: the bench plays the ROB head and cache.
module tb_rob_commit;
  import rob_commit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        alloc_valid;
  logic        alloc_ready;
  logic [2:0]  alloc_tag, head, tail;
  logic [3:0]  empty_entries;
  logic [2:0]  state_head;
  logic [31:0] addr_head, pc_head, value_head, instr_head;
  logic [1:0]  mode_head;
  logic [5:0]  write_head;
  logic [2:0]  state_head_write;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        st_req;
  logic [31:0] st_addr, st_data;
  logic        st_grant, st_done;
  logic        exc_valid;
  logic [31:0] exc_pc, exc_addr;
  logic [1:0]  exc_mode;
  logic        rob_clean;
  logic [31:0] commit_count;

  typedef struct packed {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [2:0]  exp_head = 3'd0;
  logic [2:0]  exp_tail = 3'd0;
  logic [31:0] exp_count = 32'd0;

  localparam logic [5:0] MASK_ST = 6'b100000;

  always #5 clk = ~clk;

  rob_commit dut (
    .clk                (clk),
    .reset              (reset),
    .i_alloc_valid      (alloc_valid),
    .o_alloc_ready      (alloc_ready),
    .o_alloc_tag        (alloc_tag),
    .o_head             (head),
    .o_tail             (tail),
    .i_empty_entries    (empty_entries),
    .i_state_head       (state_head),
    .i_addr_head        (addr_head),
    .i_pc_head          (pc_head),
    .i_value_head       (value_head),
    .i_instr_head       (instr_head),
    .i_mode_head        (mode_head),
    .o_write_head       (write_head),
    .o_state_head_write (state_head_write),
    .o_rf_we            (rf_we),
    .o_rf_waddr         (rf_waddr),
    .o_rf_wdata         (rf_wdata),
    .o_st_req           (st_req),
    .o_st_addr          (st_addr),
    .o_st_data          (st_data),
    .i_st_grant         (st_grant),
    .i_st_done          (st_done),
    .o_exc_valid        (exc_valid),
    .o_exc_pc           (exc_pc),
    .o_exc_addr         (exc_addr),
    .o_exc_mode         (exc_mode),
    .o_rob_clean        (rob_clean),
    .o_commit_count     (commit_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; alloc_valid = 1'b0; empty_entries = 4'd8;
    state_head = ROB_STATE_UNUSED; addr_head = '0; pc_head = '0;
    value_head = '0; instr_head = '0; mode_head = '0;
    st_grant = 1'b0; st_done = 1'b0;
    tick(); tick();
    reset = 1'b0;
    #1;
    n_tests++;
    if ({head, tail} !== 6'd0) begin
      n_fail++; $display("FAIL reset_ptrs: got %h expected 0", {head, tail});
    end
    n_tests++;
    if (commit_count !== 32'd0) begin
      n_fail++; $display("FAIL reset_count: got %0d expected 0", commit_count);
    end
    n_tests++;
    if (alloc_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_alloc_ready: got %b expected 1", alloc_ready);
    end
    n_tests++;
    if ({rf_we, st_req, exc_valid, rob_clean, write_head} !== 10'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %b expected 0",
                         {rf_we, st_req, exc_valid, rob_clean, write_head});
    end
  endtask

  task automatic test_alloc();
    for (int i = 0; i < 8; i++) begin
      alloc_valid = 1'b1; empty_entries = 4'(8 - i);
      #1;
      n_tests++;
      if ({alloc_ready, alloc_tag} !== {1'b1, 3'(i)}) begin
        n_fail++; $display("FAIL alloc_grant[%0d]: got %b/%0d expected 1/%0d",
                           i, alloc_ready, alloc_tag, i);
      end
      tick();
      exp_tail = exp_tail + 3'd1;
    end
    n_tests++;
    if (tail !== 3'd0) begin
      n_fail++; $display("FAIL alloc_wrap: got %0d expected 0", tail);
    end
    empty_entries = 4'd0;
    #1;
    n_tests++;
    if (alloc_ready !== 1'b0) begin
      n_fail++; $display("FAIL alloc_full_ready: got %b expected 0", alloc_ready);
    end
    tick();
    n_tests++;
    if ({tail, head} !== {exp_tail, exp_head}) begin
      n_fail++; $display("FAIL alloc_full_ptrs: got %0d/%0d expected %0d/%0d",
                         tail, head, exp_tail, exp_head);
    end
    alloc_valid = 1'b0; empty_entries = 4'd8;
  endtask

  task automatic test_complete();
    state_head = ROB_STATE_BUSY;
    #1;
    n_tests++;
    if ({write_head, rf_we} !== 7'd0) begin
      n_fail++; $display("FAIL busy_no_action: got %b expected 0", {write_head, rf_we});
    end
    tick();
    n_tests++;
    if (head !== exp_head) begin
      n_fail++; $display("FAIL busy_head: got %0d expected %0d", head, exp_head);
    end
    state_head = ROB_STATE_COMPLETE; instr_head = 32'h0000_02B3; value_head = 32'h1234;
    sb.push_back('{we: 1'b1, waddr: 5'd5, wdata: 32'h1234});
    exp_head = exp_head + 3'd1; exp_count = exp_count + 32'd1;
    #1;
    n_tests++;
    if ({write_head, state_head_write} !== {MASK_ST, 3'(ROB_STATE_UNUSED)}) begin
      n_fail++; $display("FAIL complete_write_head: got %b/%0d expected %b/0",
                         write_head, state_head_write, MASK_ST);
    end
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++; $display("FAIL complete_sb: got empty queue expected entry");
    end else begin
      e = sb.pop_front();
      if ({rf_we, rf_waddr, rf_wdata} !== e) begin
        n_fail++; $display("FAIL complete_rf: got %b/%0d/%h expected %b/%0d/%h",
                           rf_we, rf_waddr, rf_wdata, e.we, e.waddr, e.wdata);
      end
    end
    tick();
    state_head = ROB_STATE_UNUSED;
    n_tests++;
    if ({head, commit_count} !== {exp_head, exp_count}) begin
      n_fail++; $display("FAIL complete_ptr_count: got %0d/%0d expected %0d/%0d",
                         head, commit_count, exp_head, exp_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] instrs [4];
    logic [31:0] vals   [4];
    exp_t        exps   [4];
    instrs[0] = 32'h0000_0513; vals[0] = 32'h0000_CAFE; exps[0] = '{1'b1, 5'd10, 32'h0000_CAFE};
    instrs[1] = 32'h0000_0033; vals[1] = 32'h0000_0005; exps[1] = '{1'b0, 5'd0, 32'h0};
    instrs[2] = 32'h0000_0FB7; vals[2] = 32'hDEAD_0000; exps[2] = '{1'b1, 5'd31, 32'hDEAD_0000};
    instrs[3] = 32'h0011_2023; vals[3] = 32'h0000_0077; exps[3] = '{1'b0, 5'd0, 32'h0};
    for (int i = 0; i < 4; i++) begin
      state_head = ROB_STATE_COMPLETE; instr_head = instrs[i]; value_head = vals[i];
      sb.push_back(exps[i]);
      exp_head = exp_head + 3'd1; exp_count = exp_count + 32'd1;
      #1;
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++; $display("FAIL b2b_sb[%0d]: got empty queue expected entry", i);
      end else begin
        e = sb.pop_front();
        if ({write_head, rf_we, rf_waddr, rf_wdata} !== {MASK_ST, e}) begin
          n_fail++; $display("FAIL b2b_retire[%0d]: got %b/%b/%0d/%h expected %b/%b/%0d/%h",
                             i, write_head, rf_we, rf_waddr, rf_wdata,
                             MASK_ST, e.we, e.waddr, e.wdata);
        end
      end
      tick();
      n_tests++;
      if ({head, commit_count} !== {exp_head, exp_count}) begin
        n_fail++; $display("FAIL b2b_ptr[%0d]: got %0d/%0d expected %0d/%0d",
                           i, head, commit_count, exp_head, exp_count);
      end
    end
    state_head = ROB_STATE_UNUSED;
  endtask

  task automatic test_store();
    logic [31:0] exp_st;
    logic [8:0]  exp_wh;
    addr_head = 32'h100; value_head = 32'hAB; instr_head = 32'h0011_2023;
    sb.push_back('{we: 1'b0, waddr: 5'd0, wdata: 32'h0});
    for (int c = 1; c <= 6; c++) begin
      state_head = (c <= 3) ? ROB_STATE_WAITING_CACHE : ROB_STATE_ACCESSING_CACHE;
      st_grant   = (c == 3);
      st_done    = (c == 6);
      #1;
      n_tests++;
      exp_st = (c <= 3) ? 32'h1 : 32'h0;
      if ({st_req, st_addr, st_data} !== {exp_st[0], (c <= 3) ? 32'h100 : 32'h0,
                                          (c <= 3) ? 32'hAB : 32'h0}) begin
        n_fail++; $display("FAIL store_req[%0d]: got %b/%h/%h expected %b", c,
                           st_req, st_addr, st_data, exp_st[0]);
      end
      n_tests++;
      exp_wh = (c == 3) ? {MASK_ST, 3'(ROB_STATE_ACCESSING_CACHE)} :
               (c == 6) ? {MASK_ST, 3'(ROB_STATE_UNUSED)} : 9'd0;
      if ({write_head, state_head_write} !== exp_wh) begin
        n_fail++; $display("FAIL store_write_head[%0d]: got %b expected %b", c,
                           {write_head, state_head_write}, exp_wh);
      end
      if (c == 6) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL store_sb: got empty queue expected entry");
        end else begin
          e = sb.pop_front();
          if ({rf_we, rf_waddr, rf_wdata} !== e) begin
            n_fail++; $display("FAIL store_rf: got %b expected %b", rf_we, e.we);
          end
        end
        exp_head = exp_head + 3'd1; exp_count = exp_count + 32'd1;
      end
      tick();
      n_tests++;
      if ({head, commit_count} !== {exp_head, exp_count}) begin
        n_fail++; $display("FAIL store_ptr[%0d]: got %0d/%0d expected %0d/%0d",
                           c, head, commit_count, exp_head, exp_count);
      end
    end
    state_head = ROB_STATE_UNUSED; st_grant = 1'b0; st_done = 1'b0;
  endtask

  task automatic test_exception();
    alloc_valid = 1'b1; empty_entries = 4'd8;
    tick(); tick(); tick();
    exp_tail = exp_tail + 3'd3;
    n_tests++;
    if (tail !== exp_tail) begin
      n_fail++; $display("FAIL exc_pre_tail: got %0d expected %0d", tail, exp_tail);
    end
    state_head = ROB_STATE_EXCEPTION; pc_head = 32'h40; addr_head = 32'h44; mode_head = 2'b11;
    #1;
    n_tests++;
    if ({exc_valid, exc_pc, exc_addr, exc_mode} !== {1'b1, 32'h40, 32'h44, 2'b11}) begin
      n_fail++; $display("FAIL exc_report: got %b/%h/%h/%b expected 1/40/44/11",
                         exc_valid, exc_pc, exc_addr, exc_mode);
    end
    n_tests++;
    if ({rob_clean, alloc_ready, rf_we, write_head} !== {2'b10, 7'd0}) begin
      n_fail++; $display("FAIL exc_clean: got %b expected 100000000",
                         {rob_clean, alloc_ready, rf_we, write_head});
    end
    tick();
    state_head = ROB_STATE_UNUSED;
    exp_head = 3'd0; exp_tail = 3'd0;
    #1;
    n_tests++;
    if ({head, tail, commit_count} !== {exp_head, exp_tail, exp_count}) begin
      n_fail++; $display("FAIL exc_ptrs: got %0d/%0d/%0d expected 0/0/%0d",
                         head, tail, commit_count, exp_count);
    end
    n_tests++;
    if ({rob_clean, exc_valid, alloc_ready} !== 3'b000) begin
      n_fail++; $display("FAIL exc_flush: got %b expected 000",
                         {rob_clean, exc_valid, alloc_ready});
    end
    tick();
    n_tests++;
    if ({alloc_ready, alloc_tag, tail} !== {1'b1, 3'd0, 3'd0}) begin
      n_fail++; $display("FAIL exc_resume: got %b/%0d/%0d expected 1/0/0",
                         alloc_ready, alloc_tag, tail);
    end
    tick();
    exp_tail = exp_tail + 3'd1;
    alloc_valid = 1'b0;
    n_tests++;
    if (tail !== exp_tail) begin
      n_fail++; $display("FAIL exc_post_alloc: got %0d expected %0d", tail, exp_tail);
    end
  endtask

  task automatic test_wrap_full();
    empty_entries = 4'd8;
    for (int i = 0; i < 7; i++) begin
      state_head = ROB_STATE_COMPLETE; instr_head = 32'h0000_0033; value_head = 32'(i);
      alloc_valid = (i < 6);
      sb.push_back('{we: 1'b0, waddr: 5'd0, wdata: 32'h0});
      exp_head = exp_head + 3'd1; exp_count = exp_count + 32'd1;
      if (i < 6) exp_tail = exp_tail + 3'd1;
      #1;
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++; $display("FAIL fill_sb[%0d]: got empty queue expected entry", i);
      end else begin
        e = sb.pop_front();
        if ({write_head, rf_we, rf_waddr, rf_wdata} !== {MASK_ST, e}) begin
          n_fail++; $display("FAIL fill_retire[%0d]: got %b/%b expected %b/%b",
                             i, write_head, rf_we, MASK_ST, e.we);
        end
      end
      tick();
    end
    n_tests++;
    if ({head, tail} !== {3'd7, 3'd7}) begin
      n_fail++; $display("FAIL wrap_setup: got %0d/%0d expected 7/7", head, tail);
    end
    empty_entries = 4'd0; alloc_valid = 1'b1;
    state_head = ROB_STATE_COMPLETE; instr_head = 32'h0000_03B3; value_head = 32'h77;
    sb.push_back('{we: 1'b1, waddr: 5'd7, wdata: 32'h77});
    exp_head = exp_head + 3'd1; exp_count = exp_count + 32'd1;
    #1;
    n_tests++;
    if (alloc_ready !== 1'b0) begin
      n_fail++; $display("FAIL full_retire_ready: got %b expected 0", alloc_ready);
    end
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++; $display("FAIL full_sb: got empty queue expected entry");
    end else begin
      e = sb.pop_front();
      if ({rf_we, rf_waddr, rf_wdata} !== e) begin
        n_fail++; $display("FAIL full_retire_rf: got %b/%0d/%h expected %b/%0d/%h",
                           rf_we, rf_waddr, rf_wdata, e.we, e.waddr, e.wdata);
      end
    end
    tick();
    n_tests++;
    if ({head, tail, commit_count} !== {3'd0, 3'd7, exp_count}) begin
      n_fail++; $display("FAIL full_wrap_ptrs: got %0d/%0d/%0d expected 0/7/%0d",
                         head, tail, commit_count, exp_count);
    end
    state_head = ROB_STATE_UNUSED; empty_entries = 4'd1;
    #1;
    n_tests++;
    if ({alloc_ready, alloc_tag} !== {1'b1, 3'd7}) begin
      n_fail++; $display("FAIL full_next_alloc: got %b/%0d expected 1/7", alloc_ready, alloc_tag);
    end
    tick();
    alloc_valid = 1'b0;
    n_tests++;
    if (tail !== 3'd0) begin
      n_fail++; $display("FAIL full_tail_wrap: got %0d expected 0", tail);
    end
  endtask

  initial begin
    test_reset();
    test_alloc();
    test_complete();
    test_back_to_back();
    test_store();
    test_exception();
    test_wrap_full();
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
